// File: rtl/dcim_pkg.sv
// Shared widths and FSM encoding for the DCIM host driver slice.
package dcim_pkg;
    localparam int DATA_W  = 32;
    localparam int PROD_W  = 64;
    localparam int N_TERMS = 64;
    localparam int ADDR_W  = 6;
    localparam int ACC_W   = PROD_W + ADDR_W;

    typedef enum logic [2:0] {
        IDLE, INIT_REQ, LOAD, WAIT_DONE, RUN, DRAIN, RESULT
    } state_t;
endpackage

// File: rtl/dcim_host_driver_if.sv
// Job control, weight/activation streams, macro pins and result port of the DCIM host driver.
// slave = driver view, master = host plus macro view.
interface dcim_host_driver_if;
    import dcim_pkg::*;

    logic              start;
    logic              reload;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              pe_ce;
    logic              init_enable;
    logic [DATA_W-1:0] data_in;
    logic [PROD_W-1:0] data_out;
    logic              init_done;
    logic              valid_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;
    logic              err;

    modport slave (
        input  start, reload, w_valid, w_data, a_valid, a_data,
               data_out, init_done, valid_out, res_ready,
        output w_ready, a_ready, pe_ce, init_enable, data_in,
               res_valid, res_data, busy, err
    );

    modport master (
        output start, reload, w_valid, w_data, a_valid, a_data,
               data_out, init_done, valid_out, res_ready,
        input  w_ready, a_ready, pe_ce, init_enable, data_in,
               res_valid, res_data, busy, err
    );
endinterface

// File: rtl/dcim_tag_pipe.sv
// Marks which macro output cycles carry a product we issued; DEPTH cycles from push to tag_out.
// Free-running shift, never stalls.
module dcim_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    output logic tag_out,
    output logic empty
);
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[DEPTH-2:0], push};
    end

    assign tag_out = sr_q[DEPTH-1];
    assign empty   = ~|sr_q;
endmodule

// File: rtl/dcim_host_driver.sv
// Loads weights into the DCIM macro, streams activations, returns the 64-term dot product.
// Result ~PROD_LAT+2 cycles after the last activation; streams and result are valid/ready, result held until res_ready.
module dcim_host_driver
    import dcim_pkg::*;
#(
    parameter int PROD_LAT = 3,
    parameter int TIMEOUT  = 16
) (
    input logic              clk,
    input logic              rst_n,
    dcim_host_driver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, acnt_q;
    logic [TW-1:0]     tcnt_q;
    logic [PW-1:0]     pcnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0] din_q;
    logic              wl_q, err_q;

    logic              w_ready_c, a_ready_c, pe_ce_c, init_en_c, res_valid_c;
    logic [DATA_W-1:0] data_in_c;
    logic [ACC_W-1:0]  res_data_c;
    logic              w_hs, a_hs, tag_out, tag_empty, acc_en, miss;
    logic              start_ok, res_hs, timeout;

    assign w_hs     = (state_q == LOAD) && bus.w_valid;
    assign a_hs     = (state_q == RUN) && bus.a_valid;
    assign acc_en   = tag_out && bus.valid_out;
    assign miss     = tag_out && !bus.valid_out;
    assign start_ok = (state_q == IDLE) && bus.start;
    assign res_hs   = (state_q == RESULT) && bus.res_ready;
    assign timeout  = (state_q == WAIT_DONE) && !bus.init_done && (tcnt_q == TW'(TIMEOUT - 1));

    dcim_tag_pipe #(.DEPTH(PROD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (a_hs),
        .tag_out (tag_out),
        .empty   (tag_empty)
    );

    always_comb begin
        state_d     = state_q;
        w_ready_c   = 1'b0;
        a_ready_c   = 1'b0;
        pe_ce_c     = 1'b0;
        init_en_c   = 1'b0;
        data_in_c   = din_q;
        res_valid_c = 1'b0;
        res_data_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start)
                    state_d = (!bus.reload && wl_q && bus.init_done) ? RUN : INIT_REQ;
            end
            INIT_REQ: begin
                init_en_c = 1'b1;
                pe_ce_c   = 1'b1;
                data_in_c = '0;
                state_d   = LOAD;
            end
            LOAD: begin
                w_ready_c = 1'b1;
                pe_ce_c   = bus.w_valid;
                if (bus.w_valid) data_in_c = bus.w_data;
                if (w_hs && wcnt_q == ADDR_W'(N_TERMS - 1)) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Keep the macro clocked so it can finish its load sequence.
                pe_ce_c = 1'b1;
                if (bus.init_done) state_d = RUN;
                else if (timeout)  state_d = IDLE;
            end
            RUN: begin
                a_ready_c = 1'b1;
                pe_ce_c   = bus.a_valid;
                if (bus.a_valid) data_in_c = bus.a_data;
                if (a_hs && acnt_q == ADDR_W'(N_TERMS - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (tag_empty && pcnt_q == PW'(N_TERMS)) state_d = RESULT;
            end
            RESULT: begin
                res_valid_c = 1'b1;
                res_data_c  = acc_q;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acnt_q  <= '0;
            tcnt_q  <= '0;
            pcnt_q  <= '0;
            acc_q   <= '0;
            din_q   <= '0;
            wl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= data_in_c;
            // Counters wrap to zero after N_TERMS, ready for the next job.
            if (w_hs) wcnt_q <= wcnt_q + ADDR_W'(1);
            if (a_hs) acnt_q <= acnt_q + ADDR_W'(1);
            if (state_q == WAIT_DONE) tcnt_q <= tcnt_q + TW'(1);
            else                      tcnt_q <= '0;
            if (state_q == WAIT_DONE && bus.init_done) wl_q <= 1'b1;
            else if (timeout)                           wl_q <= 1'b0;
            if (start_ok)        err_q <= 1'b0;
            if (timeout || miss) err_q <= 1'b1;
            if (res_hs) begin
                acc_q  <= '0;
                pcnt_q <= '0;
            end else if (acc_en) begin
                acc_q  <= acc_q + ACC_W'(bus.data_out);
                pcnt_q <= pcnt_q + PW'(1);
            end
        end
    end

    assign bus.w_ready     = w_ready_c;
    assign bus.a_ready     = a_ready_c;
    assign bus.pe_ce       = pe_ce_c;
    assign bus.init_enable = init_en_c;
    assign bus.data_in     = data_in_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.res_data    = res_data_c;
    assign bus.busy        = (state_q != IDLE);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_dcim_host_driver.sv
// Directed bench for dcim_host_driver with a behavioural DCIM macro and a result scoreboard.
module tb_dcim_host_driver;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tie0  = 1'b0;
    int checks = 0, failures = 0;
    int n_init = 0, n_res = 0, pe_bad = 0, gaps = 0;
    logic [69:0] exp_q[$];
    logic [31:0] tw[64], ta[64];

    dcim_host_driver_if bif();
    dcim_host_driver #(.PROD_LAT(3), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;

    // Macro model: loads 64 words after init, needs two more clocked cycles
    // before RUN, then multiplies with a 3-cycle free-running product pipe.
    localparam int M_IDLE = 0, M_LOAD = 1, M_FIN = 2, M_RUN = 3;
    int mmode = M_IDLE, maddr = 0, mfcnt = 0;
    logic [31:0] mw[64];
    logic [63:0] mp0 = '0, mp1 = '0, mp2 = '0;
    logic [2:0]  mv = '0;

    assign bif.data_out  = mp2;
    assign bif.valid_out = mv[2];
    assign bif.init_done = !tie0 && (mmode == M_RUN || (mmode == M_FIN && mfcnt == 1));

    always @(posedge clk) begin
        mp0   <= '0;
        mv[0] <= 1'b0;
        if (bif.pe_ce === 1'b1) begin
            if (bif.init_enable === 1'b1) begin
                mmode <= M_LOAD; maddr <= 0;
            end else if (mmode == M_LOAD) begin
                mw[maddr] <= bif.data_in;
                if (maddr == 63) begin mmode <= M_FIN; mfcnt <= 0; maddr <= 0; end
                else maddr <= maddr + 1;
            end else if (mmode == M_FIN) begin
                mfcnt <= mfcnt + 1;
                if (mfcnt == 1) mmode <= M_RUN;
            end else if (mmode == M_RUN) begin
                mp0   <= 64'(mw[maddr]) * 64'(bif.data_in);
                mv[0] <= 1'b1;
                maddr <= (maddr + 1) % 64;
            end
        end
        mp1     <= mp0;
        mp2     <= mp1;
        mv[2:1] <= mv[1:0];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({bif.w_ready, bif.a_ready, bif.pe_ce, bif.init_enable, bif.data_in,
                     bif.res_valid, bif.res_data, bif.busy, bif.err});
    endfunction

    always @(negedge clk) begin
        if (bif.init_enable === 1'b1) n_init++;
        if (bif.w_ready === 1'b1 && bif.pe_ce !== bif.w_valid) pe_bad++;
        if (bif.a_ready === 1'b1 && bif.pe_ce !== bif.a_valid) pe_bad++;
        if ((bif.w_ready && !bif.w_valid) || (bif.a_ready && !bif.a_valid)) gaps++;
        if (bif.res_valid === 1'b1 && bif.res_ready === 1'b1) begin
            n_res++;
            check("result_expected", 128'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("res_data", bif.res_data, exp_q.pop_front());
        end
    end

    task automatic do_start(input logic rl);
        @(posedge clk); #1;
        bif.start = 1'b1; bif.reload = rl;
        @(posedge clk); #1;
        bif.start = 1'b0; bif.reload = 1'b0;
    endtask

    task automatic send_w(input int gap);
        int k = 0, g = 0;
        logic hs;
        while (k < 64 && g < 2000) begin
            bif.w_valid = ($urandom_range(99) >= gap);
            bif.w_data  = bif.w_valid ? tw[k] : $urandom();
            @(negedge clk); hs = bif.w_valid & bif.w_ready;
            @(posedge clk); #1;
            if (hs) k++;
            g++;
        end
        bif.w_valid = 1'b0;
        check("w_stream_accepted", k, 64);
    endtask

    task automatic send_a(input int gap, input int lim);
        int k = 0, g = 0;
        logic hs;
        while (k < lim && g < 2000) begin
            bif.a_valid = ($urandom_range(99) >= gap);
            bif.a_data  = bif.a_valid ? ta[k] : $urandom();
            @(negedge clk); hs = bif.a_valid & bif.a_ready;
            @(posedge clk); #1;
            if (hs) k++;
            g++;
        end
        bif.a_valid = 1'b0;
        check("a_stream_accepted", k, lim);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bif.busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        check({tag, "_job_completes"}, 128'(n < 500), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nw;
        bif.start = 1'b0; bif.reload = 1'b0; bif.res_ready = 1'b1;
        bif.w_valid = 1'b0; bif.w_data = '0; bif.a_valid = 1'b0; bif.a_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs(), 0);

        // Weights k+1, activations 2 -> 2*sum(1..64)
        for (int k = 0; k < 64; k++) begin tw[k] = 32'(k + 1); ta[k] = 32'd2; end
        exp_q.push_back(70'd4160);
        do_start(1'b1); send_w(0); send_a(0, 64); wait_idle("t1");
        check("t1_busy_low", bif.busy, 0);
        check("t1_err_low", bif.err, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // Weights retained, all-ones activations, no re-init
        n0 = n_init;
        for (int k = 0; k < 64; k++) ta[k] = 32'hFFFF_FFFF;
        exp_q.push_back(70'h81F_FFFF_F7E0);
        do_start(1'b0); send_a(0, 64); wait_idle("t2");
        check("t2_no_init_pulse", n_init, n0);
        check("t2_queue_empty", exp_q.size(), 0);

        // 50% valid gaps on both streams
        gaps = 0;
        for (int k = 0; k < 64; k++) ta[k] = 32'd2;
        exp_q.push_back(70'd4160);
        do_start(1'b1); send_w(50); send_a(50, 64); wait_idle("t3");
        check("t3_pe_ce_follows_valid", pe_bad, 0);
        check("t3_gaps_seen", 128'(gaps > 0), 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // Result back-pressure: held stable, starts ignored
        bif.res_ready = 1'b0;
        n0 = n_init;
        for (int k = 0; k < 64; k++) ta[k] = 32'(k);
        exp_q.push_back(70'd87360);
        do_start(1'b0); send_a(0, 64);
        nw = 0;
        while (bif.res_valid !== 1'b1 && nw < 100) begin @(negedge clk); nw++; end
        check("t5_res_valid", bif.res_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bif.start = (i % 4 == 0);
            @(negedge clk);
            check("t5_hold_valid", bif.res_valid, 1);
            check("t5_hold_data", bif.res_data, 87360);
            check("t5_hold_busy", bif.busy, 1);
        end
        @(posedge clk); #1;
        bif.start = 1'b1; bif.res_ready = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        @(negedge clk);
        check("t5_start_ignored_busy", bif.busy, 0);
        check("t5_no_init_pulse", n_init, n0);
        check("t5_queue_empty", exp_q.size(), 0);

        // init_done stuck low -> timeout after exactly 16 WAIT_DONE cycles
        tie0 = 1'b1;
        do_start(1'b1); send_w(0);
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bif.busy !== 1'b1) break;
            nw++;
        end
        check("t4_wait_cycles", nw, 16);
        check("t4_err_set", bif.err, 1);
        check("t4_busy_low", bif.busy, 0);
        tie0 = 1'b0;
        n0 = n_init;
        do_start(1'b0);
        check("t4_err_cleared_by_start", bif.err, 0);
        send_w(0);
        check("t4_weights_reloaded", n_init, n0 + 1);
        for (int k = 0; k < 64; k++) ta[k] = 32'd2;
        exp_q.push_back(70'd4160);
        send_a(0, 64); wait_idle("t4");
        check("t4_queue_empty", exp_q.size(), 0);

        // Asynchronous reset at activation 30 abandons the job
        n0 = n_res;
        do_start(1'b1); send_w(0); send_a(0, 30);
        bif.a_valid = 1'b1;
        #1 check("t6_pe_ce_before_reset", bif.pe_ce, 1);
        rst_n = 1'b0;
        #1 check("t6_async_outputs", outs(), 0);
        bif.a_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_result", n_res, n0);
        exp_q.push_back(70'd4160);
        do_start(1'b1); send_w(0); send_a(0, 64); wait_idle("t6");
        check("t6_one_result", n_res, n0 + 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcim_host_driver.md
Name: dcim_host_driver

Overview:
- Host-side initiator and result consumer for the 64x32 DCIM multiplier macro.
- Accepts a 64-word weight stream and a 64-word activation stream over valid/ready, and sequences the macro's pe_ce, init_enable and data_in.
- Collects the macro's 64-bit products and returns their 64-term unsigned dot product over a valid/ready result port.
- Sits between the system bus adapter and the DCIM macro.

Parameters:
- DATA_W, 32, weight/activation word width.
- PROD_W, 64, macro product width.
- N_TERMS, 64, words per load and products per dot product (= macro depth).
- ADDR_W, 6, log2(N_TERMS).
- ACC_W, 70, accumulator width (PROD_W+ADDR_W; cannot overflow).
- PROD_LAT, 3, cycles from an issued activation on data_in (pe_ce=1) to its product on data_out.
- TIMEOUT, 16, max cycles in WAIT_DONE before error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous active-low
- start  in  1  one-cycle job request, honoured in IDLE only
- reload  in  1  sampled with start; 1 = load new weights
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted
- w_data  in  DATA_W  weight word
- a_valid  in  1  activation valid
- a_ready  out  1  activation accepted
- a_data  in  DATA_W  activation word
- pe_ce  out  1  macro clock enable
- init_enable  out  1  macro init request
- data_in  out  DATA_W  macro data input
- data_out  in  PROD_W  macro product
- init_done  in  1  macro in RUN
- valid_out  in  1  macro product valid
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  ACC_W  dot product
- busy  out  1  state != IDLE
- err  out  1  sticky init timeout, cleared by next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, weights_loaded 0, accumulator and counters 0, tag pipe 0. Reset mid-job abandons the job silently; no result is emitted.
- IDLE + start:
  - If reload or !weights_loaded, go to INIT_REQ.
  - Otherwise, if init_done=1, go to RUN.
  - Otherwise go to INIT_REQ.
- INIT_REQ, one cycle: init_enable=1, pe_ce=1, data_in=0. Go to LOAD.
- LOAD:
  - w_ready=1. pe_ce = w_valid. data_in = w_data.
  - Each w_valid&w_ready handshake increments wcnt.
  - When w_valid=0, pe_ce=0 and the macro stalls. data_in holds the last value.
  - After handshake N_TERMS-1, go to WAIT_DONE.
- WAIT_DONE:
  - pe_ce=1, w_ready=0, counter tcnt runs.
  - On init_done=1: set weights_loaded, go to RUN.
  - If tcnt reaches TIMEOUT first: set err, clear weights_loaded, go to IDLE.
- RUN:
  - a_ready=1. pe_ce = a_valid. data_in = a_data.
  - Each a handshake pushes 1 into a PROD_LAT-deep tag shift register; every other cycle pushes 0.
  - After N_TERMS handshakes, go to DRAIN.
  - Macro address wraps 63->0 on its own, so the next RUN starts at word 0.
- DRAIN:
  - a_ready=0, pe_ce=0.
  - Stays until the tag pipe is all zero and pcnt==N_TERMS, then go to RESULT.
- Accumulation, in any state:
  - When the tag pipe output is 1 and valid_out=1: acc += zero-extended data_out, pcnt++.
  - When the tag output is 1 but valid_out=0: set err and discard the product.
- RESULT:
  - res_valid=1, res_data=acc, both stable until res_ready.
  - On res_ready: clear acc and pcnt, go to IDLE.
  - res_valid&res_ready in the same cycle as a new start: start is ignored.
- Simultaneous start during busy: ignored, no queuing.

Decomposition:
- Package dcim_pkg holds:
  - state enum {IDLE, INIT_REQ, LOAD, WAIT_DONE, RUN, DRAIN, RESULT};
  - DATA_W, PROD_W, N_TERMS, ADDR_W, ACC_W constants.
- Sub-module dcim_tag_pipe: PROD_LAT-deep 1-bit shift register with async reset, plus an all-zero flag.

Test Plan:
- Load weights w[k]=k+1, activations a[k]=2, start+reload -> res_data = 2*sum(1..64) = 4160, busy low after handshake.
- Second start with reload=0, a[k]=0xFFFFFFFF -> no init_enable pulse, res_data = 2080*0xFFFFFFFF = 0x81F_FFFF_F7E0.
- Random w_valid/a_valid gaps (50%) with the same data as test 1 -> pe_ce drops on gaps, result still 4160.
- Macro init_done tied 0 -> err=1 after exactly TIMEOUT cycles in WAIT_DONE, state IDLE, weights_loaded=0.
- res_ready held low 20 cycles -> res_valid and res_data stable, start pulses ignored, busy=1.
- rst_n low during RUN at handshake 30 -> all outputs 0 asynchronously, no res_valid; the next reload job returns the correct sum.
